// File: rtl/pb_debounce_repeat.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pb_debounce_repeat: synchronise, debounce and pulse-encode one pushbutton,
// with hold-to-repeat.
// Revision: 1.0
// ============================================================================
module pb_debounce_repeat #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int REPEAT_CYCLES   = 2500000
) (
    input  logic pixel_clock,
    input  logic reset,
    input  logic PB_in,
    input  logic repeat_en,
    output logic pb_pulse,
    output logic pb_level,
    output logic pb_held
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_RP_W   = $clog2(c_RP_MAX);

    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_HOLD_LAST = c_RP_W'(HOLD_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_REP_LAST  = c_RP_W'(REPEAT_CYCLES - 1);
    localparam logic              c_RELEASED  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic              sync1_q, sync2_q;
    logic              pb_sync;
    logic [c_DB_W-1:0] db_cnt_q, db_cnt_d;
    logic              stable_q, stable_d;
    state_t            state_q;
    logic [c_RP_W-1:0] rp_cnt_q;
    logic              pulse_q, held_q;

    // Flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            sync1_q <= c_RELEASED;
            sync2_q <= c_RELEASED;
        end else begin
            sync1_q <= PB_in;
            sync2_q <= sync1_q;
        end
    end

    assign pb_sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        if (pb_sync == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == c_DB_LAST) begin
            stable_d = pb_sync;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + c_DB_W'(1);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

    // Release is tested first in every state so it beats a same-edge expiry.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rp_cnt_q <= '0;
            pulse_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (stable_q) begin
                        pulse_q  <= 1'b1;
                        rp_cnt_q <= '0;
                        held_q   <= 1'b0;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stable_q) begin
                        held_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (repeat_en && (rp_cnt_q == c_HOLD_LAST)) begin
                        pulse_q  <= 1'b1;
                        rp_cnt_q <= '0;
                        held_q   <= 1'b1;
                        state_q  <= S_REPEAT;
                    end else if (repeat_en) begin
                        rp_cnt_q <= rp_cnt_q + c_RP_W'(1);
                    end else begin
                        rp_cnt_q <= '0;
                    end
                end
                S_REPEAT: begin
                    if (!stable_q) begin
                        held_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!repeat_en) begin
                        rp_cnt_q <= '0;
                        held_q   <= 1'b0;
                        state_q  <= S_HOLD;
                    end else if (rp_cnt_q == c_REP_LAST) begin
                        pulse_q  <= 1'b1;
                        rp_cnt_q <= '0;
                    end else begin
                        rp_cnt_q <= rp_cnt_q + c_RP_W'(1);
                    end
                end
                default: begin
                    held_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pb_pulse = pulse_q;
    assign pb_level = stable_q;
    assign pb_held  = held_q;

endmodule
`default_nettype wire

// File: doc/pb_debounce_repeat.md
# pb_debounce_repeat

Conditions one raw pushbutton for the VGA graphics design. The block synchronises the pin, debounces it, and emits single-cycle press pulses with hold-to-repeat. One instance per button (up, down) sits between the board pin and `user_logic`, in the `pixel_clock` domain. Each instance replaces the bare `one_pulse_module` path, so holding a button steps the square/colour selection repeatedly.

## Interface
Parameters:
- `ACTIVE_LOW`, 1: pin polarity; 1 means the pin reads 0 when pressed.
- `DEBOUNCE_CYCLES`, 250000: consecutive cycles the synchronised level must differ before it is accepted (10 ms at 25 MHz). Must be ≥ 2.
- `HOLD_CYCLES`, 12500000: cycles from the first pulse to the first repeat pulse (0.5 s). Must be ≥ 2.
- `REPEAT_CYCLES`, 2500000: cycles between subsequent repeat pulses (0.1 s). Must be ≥ 2.

Ports:
- `pixel_clock`  in  1: the only clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `PB_in`  in  1: raw asynchronous button pin.
- `repeat_en`  in  1: 1 enables auto-repeat; 0 gives one pulse per press.
- `pb_pulse`  out  1: one-cycle pulse per accepted press and per repeat; feeds `user_logic`.
- `pb_level`  out  1: debounced level, 1 = pressed.
- `pb_held`  out  1: 1 while the FSM is in REPEAT.

## Operation
- **Synchroniser:** two flops on `PB_in`. The output is polarity-normalised to `pb_sync` (1 = pressed). On reset, both flops load the released pin level, so there is no phantom press out of reset.
- **Debouncer:** counter `db_cnt` of width clog2(DEBOUNCE_CYCLES), plus register `pb_stable` (drives `pb_level`).
  - If `pb_sync == pb_stable`: `db_cnt <= 0`.
  - Else if `db_cnt == DEBOUNCE_CYCLES-1`: `pb_stable <= pb_sync`, `db_cnt <= 0`.
  - Else: `db_cnt <= db_cnt+1`.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and is ignored.
- **FSM:** states IDLE, HOLD, REPEAT. Timer `rp_cnt` has width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
  - IDLE: if `pb_stable`, assert `pb_pulse`, set `rp_cnt <= 0`, go to HOLD.
  - HOLD: if `!pb_stable`, go to IDLE. Else if `repeat_en` and `rp_cnt == HOLD_CYCLES-1`, assert `pb_pulse`, set `rp_cnt <= 0`, go to REPEAT. Else, if `repeat_en`, `rp_cnt++`; with `repeat_en` = 0 the timer stays at 0.
  - REPEAT: if `!pb_stable`, go to IDLE. Else if `!repeat_en`, go to HOLD with `rp_cnt <= 0`. Else if `rp_cnt == REPEAT_CYCLES-1`, assert `pb_pulse` and set `rp_cnt <= 0`. Else `rp_cnt++`.
- **Registered outputs:**
  - `pb_pulse` is high only in the cycle after the edge at which the FSM decided to emit.
  - `pb_held` = (state == REPEAT).
- **Release and expiry together:** if release and timer expiry are evaluated on the same edge, release wins and no pulse is emitted.
- **Release:** never produces a pulse.
- **Counters:** never wrap. They are cleared on every match or expiry.

## Timing
- **Reset values:** `pb_pulse` = 0, `pb_level` = 0, `pb_held` = 0, state = IDLE, `db_cnt` = `rp_cnt` = 0, sync flops at the released level.
- **Press latency:** edge 0 is the first edge sampling the settled pressed pin (D = DEBOUNCE_CYCLES).
  - `pb_sync` is valid after edge 1.
  - `pb_level` rises after edge D+1.
  - `pb_pulse` is high for exactly one cycle after edge P0 = D+2.
- **Repeat pulses:** after edges P0+HOLD_CYCLES, then every REPEAT_CYCLES.
- **Release latency:** R is the first edge sampling the released pin.
  - `pb_level` falls after edge R+D+1.
  - FSM returns to IDLE after edge R+D+2.
- **Reset mid-operation:** all state clears on the next edge. A button still held is then re-detected as a new press: pulse after edge D+2, counted from the first post-reset edge.
- **Simultaneous `reset` and a press:** reset wins.

## Test plan
Bench parameters: ACTIVE_LOW=1, D=4, HOLD=10, REPEAT=5, `repeat_en`=1, edge 0 = first pressed sample.
- Clean press, pin held 8 cycles then released → `pb_level` high after edge 5. Exactly one `pb_pulse`, after edge 6. `pb_held` stays 0. `pb_level` falls after edge 13.
- Bounce: pin toggles press/release every 2 cycles for 12 cycles, then stays released → `pb_level` never rises and `pb_pulse` never fires. Then hold the pin pressed → single pulse D+2 edges after the bounce ends.
- Hold, pin released at edge 40 → pulses after edges 6, 16, 21, 26, 31, 36, 41 (7 total), none after 46. `pb_held` high from after edge 16 until after edge 46.
- `repeat_en`=0, held 40 cycles → exactly one pulse (edge 6), `pb_held` never 1. Raising `repeat_en` at edge 20 while held → next pulse after edge 30.
- Assert `reset` for 1 cycle at edge 18 during hold → all outputs 0 after edge 18. Pin still held → pulse after edge 25 (D+2 edges after edge 19, the first post-reset edge).
- Polarity: ACTIVE_LOW=0, pin driven 1 → same timing as the clean-press test. Reset with pin idle at 0 → no pulse.
